// File: rtl/arbiter_request_buffer.sv
// arbiter_request_buffer
// Requester-side front end for a round-robin switch arbiter. Each requester
// owns a small circular flit FIFO; every non-empty FIFO raises a request line,
// and the arbiter's one-hot grant pops the granted head onto a single
// registered output. Illegal grants are refused and latched in a sticky flag.
module arbiter_request_buffer #(
  parameter int NUM_REQS   = 4,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            in_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQS-1:0]            in_ready,
  output logic [NUM_REQS-1:0]            requests,
  input  logic [NUM_REQS-1:0]            grants,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_REQS)-1:0]    out_src,
  output logic                           grant_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SRC_W = $clog2(NUM_REQS);

  // Per-requester FIFO state. DEPTH is a power of two, so the pointers wrap
  // naturally at PTR_W bits.
  logic [DATA_WIDTH-1:0] mem_q    [NUM_REQS][DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q [NUM_REQS];
  logic [PTR_W-1:0]      rd_ptr_d [NUM_REQS];
  logic [PTR_W-1:0]      wr_ptr_q [NUM_REQS];
  logic [PTR_W-1:0]      wr_ptr_d [NUM_REQS];
  logic [CNT_W-1:0]      cnt_q    [NUM_REQS];
  logic [CNT_W-1:0]      cnt_d    [NUM_REQS];

  // Registered output side.
  logic                  out_valid_q,   out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,    out_data_d;
  logic [SRC_W-1:0]      out_src_q,     out_src_d;
  logic                  grant_error_q, grant_error_d;

  logic [NUM_REQS-1:0]   push;
  logic [NUM_REQS-1:0]   pop;
  logic                  grant_legal;
  logic [SRC_W-1:0]      grant_idx;
  logic [DATA_WIDTH-1:0] head_data;

  // Request and ready lines come from registered counts only, so a
  // combinational arbiter can sit on requests->grants without a loop.
  always_comb begin : req_ready_c
    // NOTE: every always_comb output gets a default before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    requests = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      requests[i] = (cnt_q[i] != '0);
      in_ready[i] = (cnt_q[i] != CNT_W'(DEPTH)) & reset;
    end
  end

  // Grant is legal when zero or one-hot onto a requesting FIFO; only a legal
  // grant pops. Also encodes the grant index and selects the head flit.
  always_comb begin : grant_c
    grant_legal = ((grants & (grants - NUM_REQS'(1))) == '0) &&
                  ((grants & ~requests) == '0);
    pop         = grant_legal ? grants : '0;
    grant_idx   = '0;
    head_data   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (pop[i]) begin
        grant_idx = SRC_W'(i);
        head_data = mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  // Next-state for pointers, counts and the registered output.
  always_comb begin : next_state_c
    push = in_valid & in_ready;
    for (int i = 0; i < NUM_REQS; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
      wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
      cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
    out_valid_d   = |pop;
    out_data_d    = (|pop) ? head_data : out_data_q;
    out_src_d     = (|pop) ? grant_idx : out_src_q;
    grant_error_d = grant_error_q | ~grant_legal;
  end

  // FIFO storage write port.
  // NOTE: the flit array has no reset; validity is tracked entirely by the
  // pointers and counts, so clearing the storage would buy nothing.
  always_ff @(posedge clk) begin : mem_write_ff
    for (int i = 0; i < NUM_REQS; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin : state_ff
    if (!reset) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_src_q     <= '0;
      grant_error_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      for (int i = 0; i < NUM_REQS; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      grant_error_q <= grant_error_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign grant_error = grant_error_q;

endmodule

// File: tb/tb_arbiter_request_buffer.sv
// Self-checking bench for arbiter_request_buffer (NUM_REQS=4, DEPTH=4,
// DATA_WIDTH=32): a table of single-cycle vectors, then hand-written
// sequences for wrap-around, round-robin delivery, protocol errors and
// asynchronous reset.
module tb_arbiter_request_buffer;

  logic         clk;
  logic         reset;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic [3:0]   requests;
  logic [3:0]   grants;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         grant_error;

  int n_checks = 0;
  int n_fail   = 0;

  arbiter_request_buffer #(
    .NUM_REQS  (4),
    .DEPTH     (4),
    .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .requests   (requests),
    .grants     (grants),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .grant_error(grant_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  in_valid;
    logic [31:0] data;      // replicated onto every lane
    logic [3:0]  grants;
    logic [3:0]  exp_req;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_data;
    logic [1:0]  exp_src;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
    in_valid = v;
    in_data  = {4{d}};
    grants   = g;
  endtask

  int          rr_ptr;
  int          delivered;
  int          cycles;
  logic [3:0]  g;

  initial begin
    // Basic single flit, then fill / backpressure / drain on requester 0.
    vecs[0]  = '{4'b0100, 32'hA5, 4'b0000, 4'b0100, 4'b1111, 1'b0, 32'h0,  2'd0, 1'b0};
    vecs[1]  = '{4'b0000, 32'h0,  4'b0100, 4'b0000, 4'b1111, 1'b1, 32'hA5, 2'd2, 1'b0};
    vecs[2]  = '{4'b0000, 32'h0,  4'b0000, 4'b0000, 4'b1111, 1'b0, 32'hA5, 2'd2, 1'b0};
    vecs[3]  = '{4'b0001, 32'h1,  4'b0000, 4'b0001, 4'b1111, 1'b0, 32'hA5, 2'd2, 1'b0};
    vecs[4]  = '{4'b0001, 32'h2,  4'b0000, 4'b0001, 4'b1111, 1'b0, 32'hA5, 2'd2, 1'b0};
    vecs[5]  = '{4'b0001, 32'h3,  4'b0000, 4'b0001, 4'b1111, 1'b0, 32'hA5, 2'd2, 1'b0};
    vecs[6]  = '{4'b0001, 32'h4,  4'b0000, 4'b0001, 4'b1110, 1'b0, 32'hA5, 2'd2, 1'b0};
    vecs[7]  = '{4'b0001, 32'h5,  4'b0000, 4'b0001, 4'b1110, 1'b0, 32'hA5, 2'd2, 1'b0};
    vecs[8]  = '{4'b0000, 32'h0,  4'b0001, 4'b0001, 4'b1111, 1'b1, 32'h1,  2'd0, 1'b0};
    vecs[9]  = '{4'b0000, 32'h0,  4'b0001, 4'b0001, 4'b1111, 1'b1, 32'h2,  2'd0, 1'b0};
    vecs[10] = '{4'b0000, 32'h0,  4'b0001, 4'b0001, 4'b1111, 1'b1, 32'h3,  2'd0, 1'b0};
    vecs[11] = '{4'b0000, 32'h0,  4'b0001, 4'b0000, 4'b1111, 1'b1, 32'h4,  2'd0, 1'b0};
    vecs[12] = '{4'b0000, 32'h0,  4'b0000, 4'b0000, 4'b1111, 1'b0, 32'h4,  2'd0, 1'b0};

    // Reset state, asserted from time zero.
    reset = 1'b0;
    drive(4'b0000, 32'h0, 4'b0000);
    #12;
    check("rst_requests",    64'(requests),    64'h0);
    check("rst_in_ready",    64'(in_ready),    64'h0);
    check("rst_out_valid",   64'(out_valid),   64'h0);
    check("rst_out_data",    64'(out_data),    64'h0);
    check("rst_out_src",     64'(out_src),     64'h0);
    check("rst_grant_error", 64'(grant_error), 64'h0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'hF);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].in_valid, vecs[i].data, vecs[i].grants);
      step();
      check($sformatf("v%0d_requests", i),    64'(requests),    64'(vecs[i].exp_req));
      check($sformatf("v%0d_in_ready", i),    64'(in_ready),    64'(vecs[i].exp_rdy));
      check($sformatf("v%0d_out_valid", i),   64'(out_valid),   64'(vecs[i].exp_ov));
      check($sformatf("v%0d_out_data", i),    64'(out_data),    64'(vecs[i].exp_data));
      check($sformatf("v%0d_out_src", i),     64'(out_src),     64'(vecs[i].exp_src));
      check($sformatf("v%0d_grant_error", i), 64'(grant_error), 64'(vecs[i].exp_err));
    end

    // Wrap-around: requester 1 held at two entries, push and pop every cycle.
    drive(4'b0010, 32'h100, 4'b0000); step();
    drive(4'b0010, 32'h101, 4'b0000); step();
    check("wrap_pre_requests", 64'(requests), 64'h2);
    for (int k = 0; k < 10; k++) begin
      drive(4'b0010, 32'h102 + 32'(k), 4'b0010);
      step();
      check($sformatf("wrap%0d_out_valid", k), 64'(out_valid), 64'h1);
      check($sformatf("wrap%0d_out_data", k),  64'(out_data),  64'h100 + 64'(k));
      check($sformatf("wrap%0d_out_src", k),   64'(out_src),   64'h1);
      check($sformatf("wrap%0d_requests", k),  64'(requests),  64'h2);
    end
    drive(4'b0000, 32'h0, 4'b0010); step();
    check("wrap_drain0_data", 64'(out_data), 64'h10A);
    check("wrap_drain0_req",  64'(requests), 64'h2);
    step();
    check("wrap_drain1_data", 64'(out_data), 64'h10B);
    check("wrap_drain1_req",  64'(requests), 64'h0);
    drive(4'b0000, 32'h0, 4'b0000); step();

    // Round-robin delivery: two flits per source, tagged 0x100*src + k.
    for (int k = 0; k < 2; k++) begin
      in_valid = 4'b1111;
      grants   = 4'b0000;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h100 * 32'(i) + 32'(k);
      step();
    end
    drive(4'b0000, 32'h0, 4'b0000);
    check("rr_pre_requests", 64'(requests), 64'hF);
    rr_ptr    = 0;
    delivered = 0;
    cycles    = 0;
    while (delivered < 8 && cycles < 20) begin
      g = 4'b0000;
      for (int o = 0; o < 4; o++) begin
        if (g == 4'b0000 && requests[(rr_ptr + o) % 4]) begin
          g[(rr_ptr + o) % 4] = 1'b1;
          rr_ptr = (rr_ptr + o + 1) % 4;
        end
      end
      grants = g;
      step();
      cycles++;
      if (out_valid) begin
        check($sformatf("rr%0d_out_src", delivered),  64'(out_src),  64'(delivered % 4));
        check($sformatf("rr%0d_out_data", delivered), 64'(out_data),
              64'h100 * 64'(delivered % 4) + 64'(delivered / 4));
        delivered++;
      end
    end
    grants = 4'b0000;
    check("rr_delivered", 64'(delivered), 64'd8);
    check("rr_post_requests", 64'(requests), 64'h0);

    // Protocol errors: multi-hot grant, then grant onto an empty FIFO.
    drive(4'b0011, 32'hC0, 4'b0000); step();
    drive(4'b0000, 32'h0, 4'b0011); step();
    check("err_multi_out_valid", 64'(out_valid),   64'h0);
    check("err_multi_flag",      64'(grant_error), 64'h1);
    check("err_multi_requests",  64'(requests),    64'h3);
    drive(4'b0000, 32'h0, 4'b1000); step();
    check("err_empty_out_valid", 64'(out_valid),   64'h0);
    check("err_empty_flag",      64'(grant_error), 64'h1);
    check("err_empty_requests",  64'(requests),    64'h3);
    drive(4'b0000, 32'h0, 4'b0001); step();
    check("err_legal_out_valid", 64'(out_valid),   64'h1);
    check("err_legal_out_data",  64'(out_data),    64'hC0);
    check("err_sticky_flag",     64'(grant_error), 64'h1);

    // Asynchronous reset mid-traffic.
    drive(4'b0100, 32'hE0, 4'b0010); step();
    check("mid_out_valid", 64'(out_valid), 64'h1);
    check("mid_out_src",   64'(out_src),   64'h1);
    drive(4'b0100, 32'hE1, 4'b0000);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid),   64'h0);
    check("arst_requests",  64'(requests),    64'h0);
    check("arst_in_ready",  64'(in_ready),    64'h0);
    check("arst_flag",      64'(grant_error), 64'h0);
    drive(4'b0000, 32'h0, 4'b0000);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arel_in_ready", 64'(in_ready), 64'hF);
    check("arel_out_data", 64'(out_data), 64'h0);
    step();
    check("arel_requests",  64'(requests),  64'h0);
    check("arel_out_valid", 64'(out_valid), 64'h0);
    drive(4'b0100, 32'h77, 4'b0000); step();
    check("fresh_requests", 64'(requests), 64'h4);
    drive(4'b0000, 32'h0, 4'b0100); step();
    check("fresh_out_valid", 64'(out_valid),   64'h1);
    check("fresh_out_data",  64'(out_data),    64'h77);
    check("fresh_out_src",   64'(out_src),     64'h2);
    check("fresh_requests2", 64'(requests),    64'h0);
    check("fresh_flag",      64'(grant_error), 64'h0);
    drive(4'b0000, 32'h0, 4'b0000); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_request_buffer.md
# arbiter_request_buffer

Requester-side front end for `arbiter_round_robin`. It holds `NUM_REQS` per-input flit FIFOs and drives one request line per non-empty FIFO into the arbiter. It consumes the arbiter's one-hot grant by popping the granted head flit onto a single registered output. It sits between router input ports and the switch arbiter, and closes the request/grant loop the arbiter only sees from the other side.

## Interface
Parameters:
- `NUM_REQS`, 4, number of requesters; must be ≥ 2.
- `DEPTH`, 4, FIFO entries per requester; must be ≥ 2 and a power of two.
- `DATA_WIDTH`, 32, flit width in bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; `reset` = 0 clears all state immediately.
- `in_valid`  in  NUM_REQS  per-requester push strobe.
- `in_data`  in  NUM_REQS*DATA_WIDTH  push data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_ready`  out  NUM_REQS  per-requester FIFO can accept a flit.
- `requests`  out  NUM_REQS  request vector to the arbiter; bit i = FIFO i non-empty.
- `grants`  in  NUM_REQS  grant vector from the arbiter; one-hot or zero.
- `out_valid`  out  1  `out_data` and `out_src` hold a granted flit this cycle.
- `out_data`  out  DATA_WIDTH  granted flit.
- `out_src`  out  $clog2(NUM_REQS)  index of the requester the flit came from.
- `grant_error`  out  1  sticky protocol-violation flag.

## Operation
- **FIFO storage.**
  - Each requester has a circular FIFO with read pointer, write pointer and count. The count is $clog2(DEPTH+1) bits wide.
  - Pointers wrap modulo `DEPTH`.
- **Push.**
  - A push to FIFO i happens when `in_valid[i] & in_ready[i]`.
  - `in_ready[i]` = (count_i != DEPTH) & `reset`. It is computed combinationally from registered state only.
  - A push while full is dropped. The FIFO state does not change.
- **Requests.**
  - `requests[i]` = (count_i != 0). It is computed combinationally from registered count only, with no input bypass.
  - A push into an empty FIFO raises `requests[i]` in the next cycle.
- **Grants.**
  - A grant is legal when `grants` is zero, or one-hot with the bit set on a FIFO whose `requests` bit is 1.
  - On a legal non-zero grant to bit g:
    - FIFO g pops its head in the same edge.
    - `out_data` ← head, `out_src` ← g, `out_valid` ← 1, all at that edge.
  - On an illegal grant (multi-hot, or a bit set on an empty FIFO):
    - No FIFO pops.
    - `out_valid` ← 0.
    - `grant_error` ← 1. It stays 1 until reset.
  - Zero grant: `out_valid` ← 0; `out_data` and `out_src` hold their previous values.
- **Simultaneous push and pop on the same FIFO:** both take effect, and the count is unchanged.
  - When full, `in_ready` is 0, so the push is not accepted even though a pop happens that cycle.
- **Ordering:** flits from one requester leave in push order. Cross-requester order is set solely by the arbiter.

## Timing
- **Reset (`reset` = 0, asynchronous):**
  - All counts and pointers = 0.
  - `requests` = 0, `in_ready` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0, `grant_error` = 0.
  - FIFO storage contents need not be cleared.
- **Reset deassertion:** `in_ready` = all ones in the first cycle after `reset` returns to 1.
- **Reset mid-operation:** all queued flits are discarded, and `out_valid` drops immediately without waiting for a clock edge.
- **Latencies:**
  - Push → request visible: 1 cycle.
  - Grant → `out_valid`: 1 cycle (registered output).
  - Pop → `requests` update: the same edge, so a FIFO holding 1 entry drops its request the cycle after its grant.
- **Throughput:** one flit per cycle total on the output. One push per requester per cycle.
- **Arbiter loop:** `requests` depends only on flops, so the arbiter's grant logic may be combinational without forming a loop.

## Test plan
- **Reset then single flit:** after reset, push 0xA5 on requester 2.
  - Next cycle: `requests` = 4'b0100.
  - Drive `grants` = 4'b0100 → next cycle `out_valid` = 1, `out_data` = 0xA5, `out_src` = 2, `requests` = 4'b0000.
- **Full / backpressure:** push 5 flits 0x1..0x5 into requester 0 with `DEPTH` = 4 and no grants.
  - `in_ready[0]` = 0 after the 4th push; the 5th flit is dropped.
  - Four grants to bit 0 → output 0x1, 0x2, 0x3, 0x4 in order, then `requests[0]` = 0.
- **Wrap-around with simultaneous push/pop:** keep requester 1 at count 2 while pushing and granting every cycle for 10 cycles.
  - Outputs appear in exact push order across the pointer wrap, and the count stays at 2.
- **Round-robin integration:** connect to `arbiter_round_robin` with `NUM_REQS` = 4. Preload each FIFO with 2 flits tagged by source.
  - `out_src` sequence visits all four sources before any repeats, and all 8 flits are delivered.
- **Protocol errors:**
  - Drive `grants` = 4'b0011 with both FIFOs non-empty → no pop, `out_valid` = 0, `grant_error` = 1.
  - Grant to an empty FIFO 3 → same response. `grant_error` stays 1 until reset.
- **Async reset mid-traffic:** assert `reset` = 0 between clock edges while FIFOs are partly full.
  - `out_valid`, `requests` and `in_ready` go to 0 immediately.
  - After release, all counts read 0 and no stale flits emerge.
